instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Upstream requester for the instruction memory hierarchy (cache plus off-chip memory). Holds the program counter and issues one instruction read at a time over the hierarchy's read_enable/address/rd_ready/inst interface. Returned instructions are buffered in a small FIFO and presented to the decode stage through a valid/ready handshake. A branch redirect flushes the FIFO and restarts fetching at a new PC.

Parameters:
ADDR_WIDTH, 8, instruction address width; one address equals one 16-bit instruction.
INST_WIDTH, 16, instruction width.
RESET_PC, 8'h00, PC value after reset.
FIFO_DEPTH, 2, fetch buffer entries; must be 2 or more.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset.
fetch_enable  in  1  allows new memory requests to be issued.
mem_read_enable  out  1  read request to the memory hierarchy.
mem_address  out  ADDR_WIDTH  request address; stable for the whole request.
mem_rd_ready  in  1  one-cycle pulse: mem_inst is valid this cycle.
mem_inst  in  INST_WIDTH  instruction returned by the hierarchy.
redirect_valid  in  1  one-cycle branch/jump redirect.
redirect_pc  in  ADDR_WIDTH  redirect target.
fetch_valid  out  1  FIFO head is valid.
fetch_inst  out  INST_WIDTH  FIFO head instruction.
fetch_pc  out  ADDR_WIDTH  address of the FIFO head instruction.
fetch_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, pc=RESET_PC, req_addr=RESET_PC, FIFO count=0.
  - Outputs: mem_read_enable=0, mem_address=RESET_PC, fetch_valid=0, fetch_inst=0, fetch_pc=0.
  - Reset applies even mid-request. The hierarchy shares this reset, so no request is left dangling.
- Registers: pc holds the next address to fetch; req_addr holds the outstanding address. mem_address is req_addr. mem_read_enable is 1 exactly in states REQ and DISCARD.
- IDLE:
  - If redirect_valid: pc<=redirect_pc, FIFO flushed, stay IDLE.
  - Else if fetch_enable && registered count<FIFO_DEPTH: req_addr<=pc, pc<=pc+1 (mod 2^ADDR_WIDTH, so 0xFF wraps to 0x00), go to REQ.
- REQ:
  - mem_read_enable=1 with mem_address=req_addr held constant until mem_rd_ready==1.
  - On mem_rd_ready with no redirect: push {req_addr, mem_inst} into the FIFO, go to IDLE.
  - Redirect without mem_rd_ready: pc<=redirect_pc, flush FIFO, go to DISCARD. The request is not aborted.
  - Redirect in the same cycle as mem_rd_ready: response dropped (no push), pc<=redirect_pc, flush, go to IDLE.
- DISCARD:
  - Keep mem_read_enable=1 with the old address until mem_rd_ready; drop the data, go to IDLE.
  - A further redirect in DISCARD only updates pc and re-flushes.
- Inter-request gap: every completed or discarded request is followed by at least one cycle with mem_read_enable=0 (the IDLE cycle). Minimum issue interval is therefore memory latency + 1.
- Issue gating: the registered count is checked at issue. A response therefore always has a free slot; no FIFO overflow is possible.
- FIFO:
  - fetch_valid = (count!=0). fetch_inst/fetch_pc are the head entry, or 0 when empty.
  - Pop occurs when fetch_valid && fetch_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pop on empty is ignored.
  - Flush sets count=0, so fetch_valid=0 from the next cycle. A flush overrides any push or pop in the same cycle.
- fetch_enable=0 blocks only new issues. An outstanding request completes normally.

Test Plan:
1. Reset release, fetch_enable=1, fetch_ready=1, memory latency 3 -> requests at 0x00, 0x01, 0x02, each followed by a 1-cycle mem_read_enable=0 gap; decode sees fetch_pc 0x00, 0x01, 0x02 with the matching mem_inst values.
2. fetch_ready=0 from reset -> two entries (0x00, 0x01) buffered, fetch_valid=1, then mem_read_enable stays 0. Raise fetch_ready -> 0x00 then 0x01 popped, and the next request is 0x02.
3. Redirect to 0x40 two cycles into a request for 0x05 -> mem_address stays 0x05 with enable high until mem_rd_ready; that data is never presented. FIFO is empty the next cycle; the next request is 0x40.
4. Redirect to 0xFE -> fetch sequence 0xFE, 0xFF, 0x00 (wrap).
5. count=1, mem_rd_ready and pop in the same cycle -> count stays 1; the new head is the just-pushed instruction.
6. reset=0 for one cycle mid-REQ -> next cycle mem_read_enable=0 and fetch_valid=0; after release the first request is RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Bundles the memory-hierarchy request bus and the decode-side fetch
// handshake of the instruction fetch unit. The master view belongs to the
// fetch unit. The slave view belongs to the memory/decode environment.
interface instruction_fetch_unit_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int INST_WIDTH = 16
);
    logic                  fetch_enable;
    logic                  mem_read_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_rd_ready;
    logic [INST_WIDTH-1:0] mem_inst;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  fetch_valid;
    logic [INST_WIDTH-1:0] fetch_inst;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  fetch_ready;

    modport master (
        input  fetch_enable,
        input  mem_rd_ready,
        input  mem_inst,
        input  redirect_valid,
        input  redirect_pc,
        input  fetch_ready,
        output mem_read_enable,
        output mem_address,
        output fetch_valid,
        output fetch_inst,
        output fetch_pc
    );

    modport slave (
        output fetch_enable,
        output mem_rd_ready,
        output mem_inst,
        output redirect_valid,
        output redirect_pc,
        output fetch_ready,
        input  mem_read_enable,
        input  mem_address,
        input  fetch_valid,
        input  fetch_inst,
        input  fetch_pc
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC and issues one read at a time to the
// instruction memory hierarchy. Returned words are queued in a small FIFO
// for decode. A redirect flushes the FIFO and restarts at a new PC. A
// redirect that arrives while a read is still outstanding lets that read
// finish in DISCARD, and its data is then dropped.
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    INST_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    instruction_fetch_unit_if.master fetch_bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  read_enable;

    logic [ADDR_WIDTH-1:0] pc_store   [FIFO_DEPTH];
    logic [INST_WIDTH-1:0] inst_store [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic push;
    logic pop;
    logic flush;
    logic has_data;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    // A redirect in any state flushes. Only a clean response in REQ is kept.
    assign flush    = fetch_bus.redirect_valid;
    assign has_data = (count != '0);
    assign push     = (state == REQ) && fetch_bus.mem_rd_ready && !fetch_bus.redirect_valid;
    assign pop      = has_data && fetch_bus.fetch_ready;

    // Request FSM. The read enable is registered and tracks the REQ/DISCARD states.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            read_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_bus.redirect_valid) begin
                        pc <= fetch_bus.redirect_pc;
                    end else if (fetch_bus.fetch_enable && (count < CNT_W'(FIFO_DEPTH))) begin
                        // Issuing only with a free slot counted now guarantees room for the reply.
                        req_addr    <= pc;
                        pc          <= pc + 1'b1;
                        state       <= REQ;
                        read_enable <= 1'b1;
                    end
                end
                REQ: begin
                    if (fetch_bus.mem_rd_ready) begin
                        state       <= IDLE;
                        read_enable <= 1'b0;
                        if (fetch_bus.redirect_valid) begin
                            pc <= fetch_bus.redirect_pc;
                        end
                    end else if (fetch_bus.redirect_valid) begin
                        // The hierarchy cannot abort, so wait out the old read.
                        pc    <= fetch_bus.redirect_pc;
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (fetch_bus.redirect_valid) begin
                        pc <= fetch_bus.redirect_pc;
                    end
                    if (fetch_bus.mem_rd_ready) begin
                        state       <= IDLE;
                        read_enable <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    read_enable <= 1'b0;
                end
            endcase
        end
    end

    // FIFO occupancy and pointers. A flush overrides any push or pop in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage. This is data only, so no reset is needed. Entries are valid only below count.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_store[wr_ptr]   <= req_addr;
            inst_store[wr_ptr] <= fetch_bus.mem_inst;
        end
    end

    assign fetch_bus.mem_read_enable = read_enable;
    assign fetch_bus.mem_address     = req_addr;
    assign fetch_bus.fetch_valid     = has_data;
    assign fetch_bus.fetch_inst      = has_data ? inst_store[rd_ptr] : '0;
    assign fetch_bus.fetch_pc        = has_data ? pc_store[rd_ptr]   : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. A behavioural memory answers
// each read after a programmable latency with inst = {~addr, addr}. Issued
// request addresses and decode pops are logged, and each scenario compares
// the logs and outputs against hand-computed values.
module tb_instruction_fetch_unit;

    localparam int AW = 8;
    localparam int IW = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    instruction_fetch_unit_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) fbus ();

    instruction_fetch_unit #(
        .ADDR_WIDTH(AW),
        .INST_WIDTH(IW),
        .RESET_PC  (8'h00),
        .FIFO_DEPTH(2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .fetch_bus(fbus.master)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int          mem_latency = 3;
    bit          mem_hold    = 1'b0;
    int          lat_cnt     = 0;
    bit          prev_en     = 1'b0;
    bit          prev_rd     = 1'b0;
    logic [7:0]  prev_addr   = '0;
    int          gap_err     = 0;
    int          addr_err    = 0;
    logic [7:0]  req_q [$];
    int          req_cyc [$];
    logic [23:0] pop_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] inst_of(input logic [7:0] a);
        return {~a, a};
    endfunction

    function automatic logic [31:0] req_at(input int i);
        if (i < req_q.size()) return 32'(req_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        if (i < pop_q.size()) return 32'(pop_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    // One clock cycle: log the pop taken at the coming edge, then at the
    // falling edge log requests, police the bus, and run the memory model.
    task automatic tick();
        if (reset && fbus.fetch_valid && fbus.fetch_ready && !fbus.redirect_valid)
            pop_q.push_back({fbus.fetch_pc, fbus.fetch_inst});
        @(negedge clock);
        cyc++;
        fbus.redirect_valid = 1'b0;
        if (fbus.mem_read_enable && !prev_en) begin
            req_q.push_back(fbus.mem_address);
            req_cyc.push_back(cyc);
        end
        if (prev_rd && fbus.mem_read_enable) gap_err++;
        if (fbus.mem_read_enable && prev_en && !prev_rd && fbus.mem_address != prev_addr) addr_err++;
        prev_en   = fbus.mem_read_enable;
        prev_addr = fbus.mem_address;
        fbus.mem_rd_ready = 1'b0;
        if (fbus.mem_read_enable) begin
            lat_cnt++;
            if (!mem_hold && lat_cnt >= mem_latency) begin
                fbus.mem_rd_ready = 1'b1;
                fbus.mem_inst     = inst_of(fbus.mem_address);
                lat_cnt           = 0;
            end
        end else begin
            lat_cnt = 0;
        end
        prev_rd = fbus.mem_rd_ready;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset               = 1'b0;
        fbus.fetch_enable   = 1'b0;
        fbus.fetch_ready    = 1'b0;
        fbus.redirect_valid = 1'b0;
        fbus.redirect_pc    = '0;
        mem_hold            = 1'b0;
        run(2);
        reset = 1'b1;
        req_q.delete();
        req_cyc.delete();
        pop_q.delete();
        gap_err  = 0;
        addr_err = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        fbus.fetch_enable   = 1'b0;
        fbus.fetch_ready    = 1'b0;
        fbus.redirect_valid = 1'b0;
        fbus.redirect_pc    = '0;
        fbus.mem_rd_ready   = 1'b0;
        fbus.mem_inst       = '0;

        // Reset state
        reset = 1'b0;
        fbus.fetch_enable = 1'b1;
        run(3);
        check_eq("rst_read_enable", 32'(fbus.mem_read_enable), 32'd0);
        check_eq("rst_mem_address", 32'(fbus.mem_address), 32'h00);
        check_eq("rst_fetch_valid", 32'(fbus.fetch_valid), 32'd0);
        check_eq("rst_fetch_inst", 32'(fbus.fetch_inst), 32'h0);
        check_eq("rst_fetch_pc", 32'(fbus.fetch_pc), 32'h0);

        // 1: streaming with latency 3
        do_reset();
        mem_latency = 3;
        fbus.fetch_enable = 1'b1;
        fbus.fetch_ready  = 1'b1;
        run(16);
        check_eq("t1_req0", req_at(0), 32'h00);
        check_eq("t1_req1", req_at(1), 32'h01);
        check_eq("t1_req2", req_at(2), 32'h02);
        check_eq("t1_interval", 32'(req_cyc.size() >= 2 ? req_cyc[1] - req_cyc[0] : -1), 32'd4);
        check_eq("t1_pop0", pop_at(0), 32'h00FF00);
        check_eq("t1_pop1", pop_at(1), 32'h01FE01);
        check_eq("t1_pop2", pop_at(2), 32'h02FD02);
        check_eq("t1_gap_err", 32'(gap_err), 32'd0);
        check_eq("t1_addr_err", 32'(addr_err), 32'd0);

        // 2: decode stalled, FIFO fills and issue stops
        do_reset();
        mem_latency = 2;
        fbus.fetch_enable = 1'b1;
        fbus.fetch_ready  = 1'b0;
        run(12);
        check_eq("t2_req_count", 32'(req_q.size()), 32'd2);
        check_eq("t2_valid", 32'(fbus.fetch_valid), 32'd1);
        check_eq("t2_head_pc", 32'(fbus.fetch_pc), 32'h00);
        check_eq("t2_head_inst", 32'(fbus.fetch_inst), 32'hFF00);
        check_eq("t2_idle_enable", 32'(fbus.mem_read_enable), 32'd0);
        fbus.fetch_ready = 1'b1;
        run(6);
        check_eq("t2_pop0", pop_at(0), 32'h00FF00);
        check_eq("t2_pop1", pop_at(1), 32'h01FE01);
        check_eq("t2_req2", req_at(2), 32'h02);

        // 3: redirect while a request is outstanding
        do_reset();
        mem_latency = 2;
        fbus.fetch_enable   = 1'b1;
        fbus.fetch_ready    = 1'b0;
        fbus.redirect_valid = 1'b1;
        fbus.redirect_pc    = 8'h04;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fbus.mem_read_enable && fbus.mem_address == 8'h05) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq("t3_reach_req5", 32'(hit), 32'd1);
        mem_hold = 1'b1;
        tick();
        check_eq("t3_pre_valid", 32'(fbus.fetch_valid), 32'd1);
        check_eq("t3_pre_pc", 32'(fbus.fetch_pc), 32'h04);
        fbus.redirect_valid = 1'b1;
        fbus.redirect_pc    = 8'h40;
        tick();
        check_eq("t3_flush_valid", 32'(fbus.fetch_valid), 32'd0);
        check_eq("t3_disc_enable", 32'(fbus.mem_read_enable), 32'd1);
        check_eq("t3_disc_addr", 32'(fbus.mem_address), 32'h05);
        tick();
        check_eq("t3_disc_enable2", 32'(fbus.mem_read_enable), 32'd1);
        check_eq("t3_disc_addr2", 32'(fbus.mem_address), 32'h05);
        mem_hold = 1'b0;
        fbus.fetch_ready = 1'b1;
        run(10);
        check_eq("t3_req1", req_at(1), 32'h05);
        check_eq("t3_req2", req_at(2), 32'h40);
        check_eq("t3_pop0", pop_at(0), 32'h40BF40);
        check_eq("t3_gap_err", 32'(gap_err), 32'd0);
        check_eq("t3_addr_err", 32'(addr_err), 32'd0);

        // 4: PC wrap
        do_reset();
        mem_latency = 1;
        fbus.fetch_enable   = 1'b1;
        fbus.fetch_ready    = 1'b1;
        fbus.redirect_valid = 1'b1;
        fbus.redirect_pc    = 8'hFE;
        run(10);
        check_eq("t4_req0", req_at(0), 32'hFE);
        check_eq("t4_req1", req_at(1), 32'hFF);
        check_eq("t4_req2", req_at(2), 32'h00);
        check_eq("t4_pop0", pop_at(0), 32'hFE01FE);
        check_eq("t4_pop1", pop_at(1), 32'hFF00FF);
        check_eq("t4_pop2", pop_at(2), 32'h00FF00);

        // 5: push and pop in the same cycle with one entry held
        do_reset();
        mem_latency = 2;
        fbus.fetch_enable = 1'b1;
        fbus.fetch_ready  = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fbus.mem_rd_ready && fbus.mem_address == 8'h01) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq("t5_reach_rd1", 32'(hit), 32'd1);
        check_eq("t5_pre_pc", 32'(fbus.fetch_pc), 32'h00);
        fbus.fetch_ready = 1'b1;
        tick();
        check_eq("t5_valid", 32'(fbus.fetch_valid), 32'd1);
        check_eq("t5_head_pc", 32'(fbus.fetch_pc), 32'h01);
        check_eq("t5_head_inst", 32'(fbus.fetch_inst), 32'hFE01);
        tick();
        check_eq("t5_empty_after", 32'(fbus.fetch_valid), 32'd0);
        check_eq("t5_pop0", pop_at(0), 32'h00FF00);
        check_eq("t5_pop_count", 32'(pop_q.size()), 32'd2);
        fbus.fetch_ready = 1'b0;

        // 6: reset in the middle of a request
        do_reset();
        mem_latency = 3;
        fbus.fetch_enable   = 1'b1;
        fbus.fetch_ready    = 1'b0;
        fbus.redirect_valid = 1'b1;
        fbus.redirect_pc    = 8'h30;
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (fbus.mem_read_enable && fbus.mem_address == 8'h31) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq("t6_reach_req31", 32'(hit), 32'd1);
        mem_hold = 1'b1;
        tick();
        check_eq("t6_pre_valid", 32'(fbus.fetch_valid), 32'd1);
        reset = 1'b0;
        tick();
        check_eq("t6_rst_enable", 32'(fbus.mem_read_enable), 32'd0);
        check_eq("t6_rst_valid", 32'(fbus.fetch_valid), 32'd0);
        check_eq("t6_rst_addr", 32'(fbus.mem_address), 32'h00);
        reset    = 1'b1;
        mem_hold = 1'b0;
        req_q.delete();
        run(6);
        check_eq("t6_first_req", req_at(0), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
